// File: rtl/core_wb_pkg.sv
// Shared write-back definitions for the 4-core result collector: widths,
// FSM state encoding and the lane packing helper.
package core_wb_pkg;

  localparam int NUM_CORES = 4;
  localparam int LANE_W    = 16;
  localparam int WORD_W    = 64;
  localparam int ADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } wb_state_e;

  typedef logic [LANE_W-1:0]                  lane_t;
  typedef logic [NUM_CORES-1:0][LANE_W-1:0]   lane_vec_t;

  // Lane i lands in bits [i*LANE_W +: LANE_W]; empty lanes are written as zero.
  function automatic logic [WORD_W-1:0] pack_lanes(input lane_vec_t lanes,
                                                    input logic [NUM_CORES-1:0] full);
    logic [WORD_W-1:0] word;
    word = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      word[i*LANE_W +: LANE_W] = full[i] ? lanes[i] : '0;
    end
    return word;
  endfunction

endpackage

// File: rtl/core_result_collector_if.sv
// Result-lane handshake and memory write bus between the cores, the
// collector (slave) and the data memory controller write side.
interface core_result_collector_if;
  import core_wb_pkg::*;

  logic [NUM_CORES-1:0] RESVALID;
  logic [NUM_CORES-1:0] RESREADY;
  logic [LANE_W-1:0]    RES1;
  logic [LANE_W-1:0]    RES2;
  logic [LANE_W-1:0]    RES3;
  logic [LANE_W-1:0]    RES4;
  logic                 MEMWRITE;
  logic [ADDR_W-1:0]    WADDR;
  logic [WORD_W-1:0]    DATAIN;

  // Core / memory side of the bus.
  modport master (
    output RESVALID, RES1, RES2, RES3, RES4,
    input  RESREADY, MEMWRITE, WADDR, DATAIN
  );

  // Collector side of the bus.
  modport slave (
    input  RESVALID, RES1, RES2, RES3, RES4,
    output RESREADY, MEMWRITE, WADDR, DATAIN
  );

endinterface

// File: rtl/core_result_collector_lane_slot.sv
// lane_slot: one-deep holding register for a single core's result with a
// full flag, valid/ready handshake and a synchronous clear.
module lane_slot
  import core_wb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enable,
  input  logic  clear,
  input  logic  valid,
  input  lane_t data,
  output logic  ready,
  output logic  full,
  output lane_t q
);

  assign ready = enable & ~full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      // NOTE: the data register is reset too, so a reset mid-job can never
      // leak a stale result into a later packed word.
      q    <= '0;
    end else if (clear) begin
      full <= 1'b0;
      q    <= '0;
    end else if (valid && ready) begin
      full <= 1'b1;
      q    <= data;
    end
  end

endmodule

// File: rtl/core_result_collector.sv
// Write-back collector: gathers one result per core, packs them into a 64-bit
// word and writes it at an advancing address. Optional FLUSH via COLLECTOR_FLUSH_EN.
module core_result_collector
  import core_wb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'd32,
  parameter int                NUM_WORDS = 4,
  parameter int                WR_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic START,
`ifdef COLLECTOR_FLUSH_EN
  input  logic FLUSH,
`endif
  core_result_collector_if.slave bus,
  output logic BUSY,
  output logic DONE
);

  localparam int WR_CYC_W = 3;

  wb_state_e            state_q, state_d;
  logic [NUM_CORES-1:0] slot_full, slot_ready;
  lane_vec_t            slot_q, lane_in;
  logic [WR_CYC_W-1:0]  wr_cyc_q;
  logic [ADDR_W-1:0]    word_cnt_q;
  logic [ADDR_W-1:0]    waddr_q;
  logic [WORD_W-1:0]    datain_q;
  logic                 flush_go, all_full, collecting, wr_last, last_word, leave_write;

  assign lane_in  = {bus.RES4, bus.RES3, bus.RES2, bus.RES1};
  assign all_full = &slot_full;

`ifdef COLLECTOR_FLUSH_EN
  assign flush_go = (state_q == COLLECT) & FLUSH & (|slot_full);
`else
  assign flush_go = 1'b0;
`endif

  // Lanes close on the flush edge so a late arrival is not captured and then cleared unwritten.
  assign collecting  = (state_q == COLLECT) & ~flush_go;
  assign wr_last     = (wr_cyc_q == WR_CYC_W'(WR_CYCLES - 1));
  assign last_word   = ({1'b0, word_cnt_q} + 17'd1) == 17'(NUM_WORDS);
  assign leave_write = (state_q == WRITE) & wr_last;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
    lane_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (collecting),
      .clear  (leave_write),
      .valid  (bus.RESVALID[gi]),
      .data   (lane_in[gi]),
      .ready  (slot_ready[gi]),
      .full   (slot_full[gi]),
      .q      (slot_q[gi])
    );
  end

  assign bus.RESREADY = slot_ready;
  assign bus.MEMWRITE = (state_q == WRITE);
  assign bus.WADDR    = waddr_q;
  assign bus.DATAIN   = datain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = COLLECT;
      COLLECT: if (all_full || flush_go) state_d = WRITE;
      WRITE:   if (wr_last) state_d = last_word ? IDLE : COLLECT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cyc_q   <= '0;
      word_cnt_q <= '0;
      waddr_q    <= BASE_ADDR;
      datain_q   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      if (state_q == IDLE && START) begin
        DONE       <= 1'b0;
        BUSY       <= 1'b1;
        waddr_q    <= BASE_ADDR;
        word_cnt_q <= '0;
      end
      if (state_q == COLLECT && state_d == WRITE) begin
        datain_q <= pack_lanes(slot_q, slot_full);
        wr_cyc_q <= '0;
      end
      if (state_q == WRITE) begin
        if (wr_last) begin
          waddr_q    <= waddr_q + 16'd1;
          word_cnt_q <= word_cnt_q + 16'd1;
          if (last_word) begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
          end
        end else begin
          wr_cyc_q <= wr_cyc_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_result_collector.sv
// Directed bench for core_result_collector: default instance (base 32, 4 words)
// plus a wrap instance (base FFFF, 2 words, 2-cycle write strobe).
module tb_core_result_collector;
  import core_wb_pkg::*;

  logic clk;
  logic rst_n;
  logic a_start, a_busy, a_done;
  logic b_start, b_busy, b_done;
`ifdef COLLECTOR_FLUSH_EN
  logic a_flush, b_flush;
`endif
  int   checks;
  int   failures;

  core_result_collector_if a_bus ();
  core_result_collector_if b_bus ();

  core_result_collector u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .START (a_start),
`ifdef COLLECTOR_FLUSH_EN
    .FLUSH (a_flush),
`endif
    .bus   (a_bus),
    .BUSY  (a_busy),
    .DONE  (a_done)
  );

  core_result_collector #(
    .BASE_ADDR (16'hFFFF),
    .NUM_WORDS (2),
    .WR_CYCLES (2)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .START (b_start),
`ifdef COLLECTOR_FLUSH_EN
    .FLUSH (b_flush),
`endif
    .bus   (b_bus),
    .BUSY  (b_busy),
    .DONE  (b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_lanes(input logic [15:0] r1, r2, r3, r4);
    a_bus.RES1 = r1;
    a_bus.RES2 = r2;
    a_bus.RES3 = r3;
    a_bus.RES4 = r4;
  endtask

  initial begin
    logic [63:0] exp_word;
    int          base;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    a_start  = 1'b0;
    b_start  = 1'b0;
`ifdef COLLECTOR_FLUSH_EN
    a_flush  = 1'b0;
    b_flush  = 1'b0;
`endif
    a_bus.RESVALID = 4'hF;
    a_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    b_bus.RESVALID = 4'h0;
    b_bus.RES1 = 16'hAAA1;
    b_bus.RES2 = 16'hAAA2;
    b_bus.RES3 = 16'hAAA3;
    b_bus.RES4 = 16'hAAA4;
    #12;

    // 1. Reset values, then all four lanes in one cycle.
    check("rst_ready",    a_bus.RESREADY, 4'h0);
    check("rst_memwrite", a_bus.MEMWRITE, 1'b0);
    check("rst_waddr",    a_bus.WADDR, 16'd32);
    check("rst_datain",   a_bus.DATAIN, 64'h0);
    check("rst_busy",     a_busy, 1'b0);
    check("rst_done",     a_done, 1'b0);
    check("rst_b_waddr",  b_bus.WADDR, 16'hFFFF);
    rst_n   = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t1_busy",  a_busy, 1'b1);
    check("t1_ready", a_bus.RESREADY, 4'hF);
    tick();
    check("t1_ready_full", a_bus.RESREADY, 4'h0);
    check("t1_no_write",   a_bus.MEMWRITE, 1'b0);
    a_bus.RESVALID = 4'h0;
    tick();
    check("t1_memwrite", a_bus.MEMWRITE, 1'b1);
    check("t1_waddr",    a_bus.WADDR, 16'd32);
    check("t1_datain",   a_bus.DATAIN, 64'h0004_0003_0002_0001);
    check("t1_ready_wr", a_bus.RESREADY, 4'h0);
    tick();
    check("t1_wr_end",   a_bus.MEMWRITE, 1'b0);
    check("t1_waddr_inc", a_bus.WADDR, 16'd33);

    // 2. Staggered lanes: core3 @0, core1 @2, core4 @3, core2 @5 -> write @6 only.
    a_lanes(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    for (int c = 0; c < 8; c++) begin
      a_bus.RESVALID = (c == 0) ? 4'b0100 :
                       (c == 2) ? 4'b0001 :
                       (c == 3) ? 4'b1000 :
                       (c == 5) ? 4'b0010 : 4'b0000;
      tick();
      check($sformatf("t2_memwrite_c%0d", c), a_bus.MEMWRITE, (c == 6));
      if (c == 6) begin
        check("t2_datain", a_bus.DATAIN, 64'h0044_0033_0022_0011);
        check("t2_waddr",  a_bus.WADDR, 16'd33);
      end
    end
    check("t2_waddr_after", a_bus.WADDR, 16'd34);

    // 3. Backpressure: core1 keeps VALID with a new value while its slot is full.
    a_lanes(16'h000A, 16'h000B, 16'h000C, 16'h000D);
    a_bus.RESVALID = 4'hF;
    tick();
    a_bus.RES1     = 16'h000E;
    a_bus.RESVALID = 4'b0001;
    check("t3_stall_full", a_bus.RESREADY, 4'h0);
    tick();
    check("t3_memwrite",  a_bus.MEMWRITE, 1'b1);
    check("t3_datain",    a_bus.DATAIN, 64'h000D_000C_000B_000A);
    check("t3_waddr",     a_bus.WADDR, 16'd34);
    check("t3_stall_wr",  a_bus.RESREADY, 4'h0);
    tick();
    check("t3_wr_end",    a_bus.MEMWRITE, 1'b0);
    check("t3_waddr_inc", a_bus.WADDR, 16'd35);
    check("t3_reopen",    a_bus.RESREADY, 4'hF);
    tick();
    check("t3_core1_taken", a_bus.RESREADY, 4'b1110);
    a_bus.RESVALID = 4'b1110;
    a_bus.RES2 = 16'h000F;
    a_bus.RES3 = 16'h0010;
    a_bus.RES4 = 16'h0011;
    tick();
    a_bus.RESVALID = 4'h0;
    tick();
    check("t3_memwrite2", a_bus.MEMWRITE, 1'b1);
    check("t3_waddr2",    a_bus.WADDR, 16'd35);
    check("t3_datain2",   a_bus.DATAIN, 64'h0011_0010_000F_000E);
    check("t3_busy_last", a_busy, 1'b1);
    check("t3_done_last", a_done, 1'b0);
    tick();
    check("t3_final_wr_end", a_bus.MEMWRITE, 1'b0);
    check("t3_done",      a_done, 1'b1);
    check("t3_busy",      a_busy, 1'b0);
    check("t3_idle_ready", a_bus.RESREADY, 4'h0);

    // 4. Full job: values 5..20 to addresses 32..35.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t4_done_clr", a_done, 1'b0);
    check("t4_busy",     a_busy, 1'b1);
    check("t4_waddr",    a_bus.WADDR, 16'd32);
    for (int k = 0; k < 4; k++) begin
      base = 5 + 4 * k;
      a_lanes(16'(base), 16'(base + 1), 16'(base + 2), 16'(base + 3));
      exp_word = {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
      a_bus.RESVALID = 4'hF;
      tick();
      a_bus.RESVALID = 4'h0;
      tick();
      check($sformatf("t4_memwrite_%0d", k), a_bus.MEMWRITE, 1'b1);
      check($sformatf("t4_waddr_%0d", k),    a_bus.WADDR, 64'(32 + k));
      check($sformatf("t4_datain_%0d", k),   a_bus.DATAIN, exp_word);
      tick();
      check($sformatf("t4_wr_end_%0d", k),   a_bus.MEMWRITE, 1'b0);
    end
    check("t4_done", a_done, 1'b1);
    check("t4_busy", a_busy, 1'b0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t4_restart_done", a_done, 1'b0);
    check("t4_restart_busy", a_busy, 1'b1);
    a_lanes(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    a_bus.RESVALID = 4'hF;
    tick();
    a_bus.RESVALID = 4'h0;
    tick();
    check("t4_restart_memwrite", a_bus.MEMWRITE, 1'b1);
    check("t4_restart_waddr",    a_bus.WADDR, 16'd32);
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t4_start_ignored", a_bus.WADDR, 16'd33);
    check("t4_still_busy",    a_busy, 1'b1);

    // 5a. Address wrap with a 2-cycle write strobe.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_bus.RESVALID = 4'hF;
    tick();
    b_bus.RESVALID = 4'h0;
    tick();
    check("t5_b_memwrite_c1", b_bus.MEMWRITE, 1'b1);
    check("t5_b_waddr_ffff",  b_bus.WADDR, 16'hFFFF);
    check("t5_b_datain",      b_bus.DATAIN, 64'hAAA4_AAA3_AAA2_AAA1);
    tick();
    check("t5_b_memwrite_c2", b_bus.MEMWRITE, 1'b1);
    check("t5_b_waddr_hold",  b_bus.WADDR, 16'hFFFF);
    tick();
    check("t5_b_wr_end",      b_bus.MEMWRITE, 1'b0);
    check("t5_b_waddr_wrap",  b_bus.WADDR, 16'h0000);
    b_bus.RESVALID = 4'hF;
    tick();
    b_bus.RESVALID = 4'h0;
    tick();
    check("t5_b_memwrite2", b_bus.MEMWRITE, 1'b1);
    check("t5_b_waddr2",    b_bus.WADDR, 16'h0000);
    tick();
    tick();
    check("t5_b_done",      b_done, 1'b1);
    check("t5_b_busy",      b_busy, 1'b0);
    check("t5_b_idle",      b_bus.MEMWRITE, 1'b0);

    // 5b. Reset mid-COLLECT with two slots full.
    a_lanes(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    a_bus.RESVALID = 4'b0011;
    tick();
    a_bus.RESVALID = 4'h0;
    check("t5_two_full", a_bus.RESREADY, 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready",    a_bus.RESREADY, 4'h0);
    check("t5_rst_memwrite", a_bus.MEMWRITE, 1'b0);
    check("t5_rst_waddr",    a_bus.WADDR, 16'd32);
    check("t5_rst_datain",   a_bus.DATAIN, 64'h0);
    check("t5_rst_busy",     a_busy, 1'b0);
    check("t5_rst_done",     a_done, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_post_rst_idle", a_bus.RESREADY, 4'h0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("t5_slots_cleared", a_bus.RESREADY, 4'hF);
    a_lanes(16'h0000, 16'h0000, 16'h000C, 16'h000D);
    a_bus.RESVALID = 4'b1100;
    tick();
    a_bus.RESVALID = 4'h0;
    check("t5_half_full", a_bus.RESREADY, 4'b0011);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t5_no_write_%0d", c), a_bus.MEMWRITE, 1'b0);
    end

`ifdef COLLECTOR_FLUSH_EN
    // 6. FLUSH: partial word written with zero-filled empty lanes.
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("t6_flush_memwrite", a_bus.MEMWRITE, 1'b1);
    check("t6_flush_datain",   a_bus.DATAIN, 64'h000D_000C_0000_0000);
    tick();
    a_bus.RES1     = 16'h0007;
    a_bus.RESVALID = 4'b0001;
    tick();
    a_bus.RESVALID = 4'h0;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("t6_core1_memwrite", a_bus.MEMWRITE, 1'b1);
    check("t6_core1_datain",   a_bus.DATAIN, 64'h0000_0000_0000_0007);
    tick();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("t6_empty_flush_c0", a_bus.MEMWRITE, 1'b0);
    tick();
    check("t6_empty_flush_c1", a_bus.MEMWRITE, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
